// File: rtl/imem_fetch_pkg.sv
// ============================================================================
// Module      : imem_fetch_pkg
// Description : Shared widths and types for the instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_fetch_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 64;

  typedef logic [ADDR_W-1:0] pc_t;
  typedef logic [DATA_W-1:0] inst_t;

  typedef struct packed {
    inst_t inst;
    pc_t   pc;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/imem_fetch_fifo.sv
// ============================================================================
// Module      : imem_fetch_fifo
// Description : Synchronous FIFO of fetch entries. Push and pop may coincide
//               at any occupancy; flush empties it and overrides both.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_fetch_fifo
  import imem_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  fetch_entry_t           i_push_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output fetch_entry_t           o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int c_ptr_w = $clog2(DEPTH);

  fetch_entry_t       r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;
  logic               w_push_en;
  logic               w_pop_en;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (c_ptr_w+1)'(DEPTH));
  assign w_pop_en  = i_pop & ~o_empty;
  // A push into a full FIFO is only accepted when a pop frees a slot
  assign w_push_en = i_push & (~o_full | w_pop_en);
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Pointer and occupancy bookkeeping; flush returns to the empty state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_en) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop_en)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_push_en, w_pop_en})
        2'b10:   r_count <= r_count + (c_ptr_w+1)'(1);
        2'b01:   r_count <= r_count - (c_ptr_w+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; cleared on reset so the head reads zero out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push_en && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/imem_fetch_unit.sv
// ============================================================================
// Module      : imem_fetch_unit
// Description : Instruction fetch requester. Issues sequential word addresses
//               to a one-cycle-latency memory port, tags returned words with
//               their PC, buffers them and hands them to decode. A redirect
//               flushes everything and restarts at a new PC.
//               Optional macro IMEM_FETCH_PERF_EN adds saturating counters of
//               delivered instructions and redirects.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_fetch_unit
  import imem_fetch_pkg::*;
#(
  parameter int  FIFO_DEPTH = 4,
  parameter pc_t RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic [DATA_W-1:0] i_imem_data,
  input  logic              i_redirect_valid,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_inst,
`ifdef IMEM_FETCH_PERF_EN
  output logic [31:0]       o_perf_fetched,
  output logic [31:0]       o_perf_redirects,
`endif
  output logic [ADDR_W-1:0] o_out_pc
);

  localparam int                c_cnt_w = $clog2(FIFO_DEPTH) + 1;
  localparam logic [c_cnt_w:0]  c_depth = (c_cnt_w+1)'(FIFO_DEPTH);

  pc_t                r_fetch_pc;
  pc_t                r_inflight_pc;
  logic               r_inflight;
  logic [c_cnt_w-1:0] w_count;
  logic [c_cnt_w:0]   w_credit;
  logic               w_full;
  logic               w_empty;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;
  fetch_entry_t       w_push_entry;
  fetch_entry_t       w_head;

  // Credit = buffered entries plus the one read still in flight; a pop in the
  // same cycle is deliberately not counted so the bound stays registered-only
  assign w_credit    = {1'b0, w_count} + {{c_cnt_w{1'b0}}, r_inflight};
  assign w_issue     = i_redirect_valid | (~w_full & (w_credit < c_depth));
  // Address is the next PC to fetch; when not issuing it simply holds
  assign o_imem_addr = i_redirect_valid ? i_redirect_pc : r_fetch_pc;

  // Anything returning or leaving in a redirect cycle belongs to the old path
  assign w_push       = r_inflight & ~i_redirect_valid;
  assign w_pop        = ~w_empty & i_out_ready & ~i_redirect_valid;
  assign w_push_entry = '{inst: i_imem_data, pc: r_inflight_pc};

  assign o_out_valid = ~w_empty;
  assign o_out_inst  = w_head.inst;
  assign o_out_pc    = w_head.pc;

  // Fetch PC advance and in-flight tracking for the one-cycle memory read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= o_imem_addr;
        r_fetch_pc    <= o_imem_addr + pc_t'(1);
      end
    end
  end

  imem_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .i_flush     (i_redirect_valid),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

`ifdef IMEM_FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_redirects;

  // Saturating counters; a head killed by a redirect is not counted as fetched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched   <= '0;
      r_perf_redirects <= '0;
    end else begin
      if (w_pop && (r_perf_fetched != '1))
        r_perf_fetched <= r_perf_fetched + 32'd1;
      if (i_redirect_valid && (r_perf_redirects != '1))
        r_perf_redirects <= r_perf_redirects + 32'd1;
    end
  end

  assign o_perf_fetched   = r_perf_fetched;
  assign o_perf_redirects = r_perf_redirects;
`endif

endmodule

`default_nettype wire
